// File: rtl/uart_rx_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_checker
// Brief    : Assembles an LSB-first UART RX frame from sampled bits, checks
//            parity and stop bit, and keeps saturating error counters.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  nRESET,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_MODE,
  input  logic                  cnt_clr,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  frame_done,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

  localparam int                   c_BCW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_BCW-1:0]     c_LAST    = c_BCW'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic [c_BCW-1:0]        r_bit_cnt;
  logic                    r_par_run;
  logic                    r_par_en;
  logic [1:0]              r_par_mode;
  logic                    r_pe_pending;
  logic                    w_par_exp;

  always_comb begin
    w_par_exp = 1'b0;
    case (r_par_mode)
      2'b00:   w_par_exp = r_par_run;
      2'b01:   w_par_exp = ~r_par_run;
      2'b10:   w_par_exp = 1'b1;
      default: w_par_exp = 1'b0;
    endcase
  end

  // frame_start overrides everything, including a same-cycle bit strobe
  always_comb begin
    w_state_nxt = r_state;
    if (frame_start) begin
      w_state_nxt = ST_DATA;
    end else if (bit_valid) begin
      case (r_state)
        ST_DATA:   if (r_bit_cnt == c_LAST) w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
        ST_PARITY: w_state_nxt = ST_STOP;
        ST_STOP:   w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_par_run    <= 1'b0;
      r_par_en     <= 1'b0;
      r_par_mode   <= 2'b00;
      r_pe_pending <= 1'b0;
      P_DATA       <= '0;
      frame_done   <= 1'b0;
      data_valid   <= 1'b0;
      par_err      <= 1'b0;
      stp_err      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      data_valid <= 1'b0;
      if (frame_start) begin
        r_bit_cnt    <= '0;
        r_par_run    <= 1'b0;
        r_par_en     <= PAR_EN;
        r_par_mode   <= PAR_MODE;
        r_pe_pending <= 1'b0;
        par_err      <= 1'b0;
        stp_err      <= 1'b0;
      end else if (bit_valid) begin
        case (r_state)
          ST_DATA: begin
            r_shift[r_bit_cnt] <= sampled_bit;
            r_par_run          <= r_par_run ^ sampled_bit;
            r_bit_cnt          <= r_bit_cnt + 1'b1;
          end
          ST_PARITY: r_pe_pending <= (sampled_bit != w_par_exp);
          ST_STOP: begin
            P_DATA     <= r_shift;
            par_err    <= r_pe_pending;
            stp_err    <= ~sampled_bit;
            frame_done <= 1'b1;
            data_valid <= ~r_pe_pending & sampled_bit;
          end
          default: ;
        endcase
      end
    end
  end

  // Counters sample the flags while frame_done is high; a clear wins and drops the event
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
    end else if (cnt_clr) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
    end else if (frame_done) begin
      if (par_err && (par_err_cnt != c_CNT_MAX)) par_err_cnt <= par_err_cnt + 1'b1;
      if (stp_err && (stp_err_cnt != c_CNT_MAX)) stp_err_cnt <= stp_err_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_frame_checker.md
# uart_rx_frame_checker

Parametrised receive-frame checker for the UART RX path. It consumes the sampled-bit stream from the data sampler and assembles the data word LSB-first. It checks parity (none/even/odd/mark/space) and the stop bit, then reports one result per frame. Saturating error counters are readable by the register file. It sits between the RX data sampler/edge counter and the RX output interface, and replaces the combinational per-frame parity compare.

## Interface
- DATA_WIDTH, 8 — data bits per frame, legal 5..9
- CNT_WIDTH, 8 — width of each error counter, legal 1..16

- CLK  in  1  — RX clock
- nRESET  in  1  — asynchronous, active-low reset
- frame_start  in  1  — one-cycle pulse: start bit validated; (re)starts a frame
- bit_valid  in  1  — one-cycle strobe: sampled_bit holds the next frame bit
- sampled_bit  in  1  — majority-sampled bit value
- PAR_EN  in  1  — parity bit present
- PAR_MODE  in  2  — 00 even, 01 odd, 10 mark (1), 11 space (0)
- cnt_clr  in  1  — synchronous clear of both error counters
- P_DATA  out  DATA_WIDTH  — received word, LSB = first data bit
- frame_done  out  1  — one-cycle pulse: frame result valid
- data_valid  out  1  — one-cycle pulse with frame_done when no error
- par_err  out  1  — parity error of last completed frame
- stp_err  out  1  — stop-bit error of last completed frame
- busy  out  1  — high in every state except IDLE
- par_err_cnt  out  CNT_WIDTH  — saturating parity-error count
- stp_err_cnt  out  CNT_WIDTH  — saturating stop-error count

## Operation
- States:
  - IDLE: default state.
  - DATA: collects DATA_WIDTH bits.
  - PARITY: entered only if PAR_EN was latched high.
  - STOP: checks the stop bit.
- IDLE→DATA on frame_start.
  - On that edge: bit counter=0, running parity=0, PAR_EN/PAR_MODE latched, par_err/stp_err cleared.
  - Config changes mid-frame have no effect.
- DATA:
  - Each bit_valid shifts sampled_bit into shift[bit_cnt] and XORs it into the running parity.
  - After bit DATA_WIDTH-1: go to PARITY if the latched PAR_EN=1, else STOP.
- PARITY, on bit_valid, compute the expected bit:
  - even: running parity
  - odd: its inverse
  - mark: 1
  - space: 0
  - pe_pending = (sampled_bit != expected). Go to STOP.
- STOP, on bit_valid: se = (sampled_bit == 0).
  - Load P_DATA from shift, par_err=pe_pending, stp_err=se.
  - Pulse frame_done; pulse data_valid iff !pe_pending && !se.
  - Return to IDLE.
- P_DATA, par_err and stp_err hold until the next completed frame. par_err/stp_err also clear on frame_start.
- Counters:
  - On frame_done, each counter increments by 1 if its error is set.
  - Saturate at 2^CNT_WIDTH-1; no wrap.
  - cnt_clr has priority over a same-cycle increment; that event is lost.
- Boundary rules:
  - frame_start in any non-IDLE state aborts the frame. No frame_done for it; restart as from IDLE.
  - frame_start and bit_valid in the same cycle: frame_start wins, the bit is dropped.
  - bit_valid in IDLE is ignored.
- Reset (any time, including mid-frame) forces IDLE. All outputs and counters go to 0, shift and pending flags to 0.

## Timing
- All outputs are registered.
- frame_done/data_valid/par_err/stp_err/P_DATA update on the clock edge that samples the stop-bit bit_valid. They are visible the cycle after the strobe.
- Counters reflect a frame's errors one cycle after frame_done is seen high.
- busy rises the cycle after frame_start and falls together with the frame_done pulse.
- No back-pressure: result is a pulse, and the consumer must capture it in that cycle.
- Minimum bit_valid spacing is 1 cycle; consecutive-cycle strobes must be handled.

## Test plan
- DATA_WIDTH=8, even parity: frame_start, bits of 0xA5 LSB-first, parity 0, stop 1.
  - P_DATA=0xA5, frame_done=data_valid=1 for one cycle, par_err=stp_err=0, counters 0.
- Odd parity: same 0xA5, parity bit 0.
  - par_err=1, data_valid=0, P_DATA=0xA5, par_err_cnt=1.
- PAR_EN=0: 0x3C, stop bit 0.
  - STOP follows 8th bit directly, stp_err=1, par_err=0, stp_err_cnt=1.
- Config and abort:
  - Mark mode with parity bit 1 → no error.
  - frame_start after 4 data bits then full 0x5A frame → exactly one frame_done, P_DATA=0x5A.
  - PAR_MODE changed mid-frame → ignored.
- CNT_WIDTH=2: five consecutive stop-error frames → stp_err_cnt=3.
  - cnt_clr coincident with the 6th error → counter=0.
- Edge cases:
  - nRESET low mid-DATA → all outputs 0, busy=0.
  - A following clean 0xFF even-parity frame (parity 0) completes correctly.
  - frame_start with bit_valid in the same cycle drops that bit.
